input_read_debounced: RTL and testbench

//  Parametrised board-input front end: synchronises the switch bank and push-buttons to Clk,

---
 rtl/input_read_debounced.sv | 126 ++++++++++++
 tb/tb_input_read_debounced.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/input_read_debounced.sv
// Board-input front end: synchronises and debounces the switch bank and push-buttons,
// presenting split switch operands plus per-button level, press pulse and mode outputs.

module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 1000000,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit TOGGLE      = 1'b0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic mode
);
  localparam int CW = $clog2(DB_COUNT);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  // Normalise polarity so 1 always means pressed.
  assign s = sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      // Idle pin level, so a button held through reset reads as a fresh press.
      sync  <= {SYNC_STAGES{ACTIVE_LOW}};
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      mode  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pin};
      press <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_COUNT - 1)) begin
        level <= s;
        press <= s;
        cnt   <= '0;
        if (TOGGLE) begin
          if (s) mode <= ~mode;
        end else begin
          mode <= s;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module input_read_debounced #(
  parameter int                 SW_WIDTH       = 16,
  parameter int                 NUM_BTN        = 3,
  parameter bit                 BTN_ACTIVE_LOW = 1'b1,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 DB_COUNT       = 1000000,
  parameter logic [NUM_BTN-1:0] TOGGLE_MASK    = 3'b110
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [SW_WIDTH-1:0]   Sw,
  input  logic [NUM_BTN-1:0]    Btn,
  output logic [SW_WIDTH/2-1:0] InputX,
  output logic [SW_WIDTH/2-1:0] InputY,
  output logic                  SwChanged,
  output logic [NUM_BTN-1:0]    BtnLevel,
  output logic [NUM_BTN-1:0]    BtnPress,
  output logic [NUM_BTN-1:0]    BtnMode
);
  localparam int CW = $clog2(DB_COUNT);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_COUNT   (DB_COUNT),
      .ACTIVE_LOW (BTN_ACTIVE_LOW),
      .TOGGLE     (TOGGLE_MASK[i])
    ) u_db (
      .Clk  (Clk),
      .Rst  (Rst),
      .pin  (Btn[i]),
      .level(BtnLevel[i]),
      .press(BtnPress[i]),
      .mode (BtnMode[i])
    );
  end

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync;
  logic [SW_WIDTH-1:0]                  sw_s, sw_last, committed;
  logic [CW-1:0]                        cs;

  assign sw_s      = sw_sync[SYNC_STAGES-1];
  assign committed = {InputX, InputY};

  // Whole word is debounced as one unit: any bit moving restarts the count,
  // so the committed word never shows a partial update.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sw_sync   <= '0;
      sw_last   <= '0;
      cs        <= '0;
      InputX    <= '0;
      InputY    <= '0;
      SwChanged <= 1'b0;
    end else begin
      sw_sync   <= {sw_sync[SYNC_STAGES-2:0], Sw};
      sw_last   <= sw_s;
      SwChanged <= 1'b0;
      if (sw_s == committed) begin
        cs <= '0;
      end else if (sw_s != sw_last) begin
        cs <= '0;
      end else if (cs == CW'(DB_COUNT - 1)) begin
        {InputX, InputY} <= sw_s;
        SwChanged        <= 1'b1;
        cs               <= '0;
      end else begin
        cs <= cs + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_input_read_debounced.sv
// Directed bench for input_read_debounced with DB_COUNT=4, SYNC_STAGES=2, active-low buttons.

module tb_input_read_debounced;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] Sw;
  logic [2:0]  Btn;
  logic [7:0]  InputX, InputY;
  logic        SwChanged;
  logic [2:0]  BtnLevel, BtnPress, BtnMode;

  int n_cmp = 0;
  int n_err = 0;

  input_read_debounced #(
    .SW_WIDTH(16), .NUM_BTN(3), .BTN_ACTIVE_LOW(1'b1),
    .SYNC_STAGES(2), .DB_COUNT(4), .TOGGLE_MASK(3'b110)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Sw(Sw), .Btn(Btn),
    .InputX(InputX), .InputY(InputY), .SwChanged(SwChanged),
    .BtnLevel(BtnLevel), .BtnPress(BtnPress), .BtnMode(BtnMode)
  );

  always #5 Clk = ~Clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst = 1'b1; Btn = 3'b111; Sw = 16'h0000;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) Rst = 1'b0;
      tick();
      n_cmp++;
      if ({InputX, InputY, SwChanged, BtnLevel, BtnPress, BtnMode} !== 26'd0) begin
        n_err++;
        $display("FAIL reset_zero cyc=%0d got X=%h Y=%h chg=%b lvl=%b prs=%b mode=%b want all 0",
                 k, InputX, InputY, SwChanged, BtnLevel, BtnPress, BtnMode);
      end
    end
  endtask

  task automatic test_btn_level;
    Btn[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if ({BtnLevel[0], BtnPress[0], BtnMode[0]} !== {1'(k >= 6), 1'(k == 6), 1'(k >= 6)}) begin
        n_err++;
        $display("FAIL btn0_press edge=%0d got lvl=%b prs=%b mode=%b want lvl=%b prs=%b mode=%b",
                 k, BtnLevel[0], BtnPress[0], BtnMode[0], k >= 6, k == 6, k >= 6);
      end
    end
    Btn[0] = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if ({BtnLevel[0], BtnMode[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL btn0_release got lvl=%b mode=%b want 0 0", BtnLevel[0], BtnMode[0]);
    end
  endtask

  task automatic test_glitch_toggle;
    Btn[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) Btn[1] = 1'b1;
      tick();
      n_cmp++;
      if (BtnPress[1] !== 1'b0) begin
        n_err++;
        $display("FAIL btn1_glitch cyc=%0d got prs=%b want 0", k, BtnPress[1]);
      end
    end
    Btn[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if ({BtnPress[1], BtnMode[1]} !== {1'(k == 6), 1'(k >= 6)}) begin
        n_err++;
        $display("FAIL btn1_final_low edge=%0d got prs=%b mode=%b want prs=%b mode=%b",
                 k, BtnPress[1], BtnMode[1], k == 6, k >= 6);
      end
    end
    Btn[1] = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if ({BtnLevel[1], BtnMode[1]} !== 2'b01) begin
      n_err++;
      $display("FAIL btn1_toggle_hold got lvl=%b mode=%b want 0 1", BtnLevel[1], BtnMode[1]);
    end
    Btn[1] = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if ({BtnLevel[1], BtnMode[1]} !== 2'b10) begin
      n_err++;
      $display("FAIL btn1_toggle_back got lvl=%b mode=%b want 1 0", BtnLevel[1], BtnMode[1]);
    end
    Btn[1] = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_simultaneous;
    Btn = 3'b100;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if (BtnPress !== ((k == 6) ? 3'b011 : 3'b000)) begin
        n_err++;
        $display("FAIL btn_simul edge=%0d got prs=%b want %b", k, BtnPress,
                 (k == 6) ? 3'b011 : 3'b000);
      end
    end
    Btn = 3'b111;
    repeat (8) tick();
  endtask

  task automatic test_sw_commit;
    Sw = 16'hA53C;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if ({SwChanged, InputX, InputY} !== {1'(k == 7), (k >= 7) ? 16'hA53C : 16'h0000}) begin
        n_err++;
        $display("FAIL sw_commit edge=%0d got chg=%b X=%h Y=%h want chg=%b word=%h",
                 k, SwChanged, InputX, InputY, k == 7, (k >= 7) ? 16'hA53C : 16'h0000);
      end
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({SwChanged, InputX, InputY} !== {1'b0, 16'hA53C}) begin
        n_err++;
        $display("FAIL sw_hold cyc=%0d got chg=%b X=%h Y=%h want 0 A5 3C",
                 k, SwChanged, InputX, InputY);
      end
    end
  endtask

  task automatic test_sw_bounce;
    Sw = 16'h0000;
    repeat (10) tick();
    n_cmp++;
    if ({InputX, InputY} !== 16'h0000) begin
      n_err++;
      $display("FAIL sw_clear got X=%h Y=%h want 00 00", InputX, InputY);
    end
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) Sw = ((k / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
      tick();
      n_cmp++;
      if ({SwChanged, InputX, InputY} !== 17'd0) begin
        n_err++;
        $display("FAIL sw_bounce cyc=%0d got chg=%b X=%h Y=%h want 0 00 00",
                 k, SwChanged, InputX, InputY);
      end
    end
    Sw = 16'h0000;
    repeat (4) tick();
  endtask

  task automatic test_reset_held;
    Btn = 3'b011;
    repeat (3) tick();
    for (int r = 0; r < 2; r++) begin
      Rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
        tick();
        n_cmp++;
        if ({InputX, InputY, SwChanged, BtnLevel, BtnPress, BtnMode} !== 26'd0) begin
          n_err++;
          $display("FAIL rst_held_zero pass=%0d cyc=%0d got lvl=%b prs=%b mode=%b want 0",
                   r, k, BtnLevel, BtnPress, BtnMode);
        end
      end
      Rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
        tick();
        n_cmp++;
        if ({BtnLevel, BtnPress} !== {(k >= 6) ? 3'b100 : 3'b000, (k == 6) ? 3'b100 : 3'b000}) begin
          n_err++;
          $display("FAIL rst_held_press pass=%0d edge=%0d got lvl=%b prs=%b want lvl=%b prs=%b",
                   r, k, BtnLevel, BtnPress, (k >= 6) ? 3'b100 : 3'b000,
                   (k == 6) ? 3'b100 : 3'b000);
        end
      end
      repeat (2) tick();
    end
  endtask

  initial begin
    test_reset();
    test_btn_level();
    test_glitch_toggle();
    test_simultaneous();
    test_sw_commit();
    test_sw_bounce();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
